// File: rtl/ram_initiator.sv
// Memory self-test master: writes seed+i to base+i for len words, reads them back and counts mismatches.
// Optional macro PARITY_CHECK_EN adds an even-parity check on mem_rdata[DW]; done follows start by 2*len+RD_LAT+1 cycles.
module ram_initiator #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW:0]   mem_rdata,
  input  logic [AW-1:0] mem_addr_echo
);

  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic [AW-1:0]             base_q;
  logic [LW-1:0]             len_q;
  logic [LW-1:0]             idx_q;
  logic [DW-1:0]             seed_q;
  logic [2:0]                drain_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      pass_q;
  logic [LW-1:0]             err_q;
  logic [AW-1:0]             ferr_q;
  logic [AW-1:0]             mem_addr_q;
  logic [DW-1:0]             mem_wdata_q;
  logic                      mem_we_q;

  // Stage 0 tracks the address currently on mem_addr; stage RD_LAT lines up with mem_rdata.
  logic [RD_LAT:0]           pv_q;
  logic [RD_LAT:0][AW-1:0]   pa_q;
  logic [RD_LAT:0][DW-1:0]   pd_q;

  logic                      last_word;
  logic                      par_err;
  logic                      cmp_vld;
  logic                      mismatch;
  logic [LW-1:0]             err_d;

  assign last_word = (idx_q == len_q - LW'(1));
  assign cmp_vld   = pv_q[RD_LAT];
  assign err_d     = (err_q == '1) ? err_q : err_q + LW'(1);

`ifdef PARITY_CHECK_EN
  assign par_err = mem_rdata[DW] ^ (^mem_rdata[DW-1:0]);
`else
  logic unused_parity;
  assign unused_parity = mem_rdata[DW];
  assign par_err       = 1'b0;
`endif

  assign mismatch = (mem_rdata[DW-1:0] != pd_q[RD_LAT]) ||
                    (mem_addr_echo != pa_q[RD_LAT]) || par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      seed_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      pv_q        <= '0;
      pa_q        <= '0;
      pd_q        <= '0;
    end else begin
      done_q           <= 1'b0;
      pv_q[RD_LAT:1]   <= pv_q[RD_LAT-1:0];
      pa_q[RD_LAT:1]   <= pa_q[RD_LAT-1:0];
      pd_q[RD_LAT:1]   <= pd_q[RD_LAT-1:0];

      if (cmp_vld && mismatch) begin
        if (err_q == '0) ferr_q <= pa_q[RD_LAT];
        err_q <= err_d;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= len;
            seed_q <= seed;
            idx_q  <= '0;
            err_q  <= '0;
            ferr_q <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q     <= S_WRITE;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= base_addr;
              mem_wdata_q <= seed;
            end
          end
        end
        S_WRITE: begin
          if (last_word) begin
            state_q    <= S_READ;
            mem_we_q   <= 1'b0;
            mem_addr_q <= base_q;
            idx_q      <= '0;
            pv_q[0]    <= 1'b1;
            pa_q[0]    <= base_q;
            pd_q[0]    <= seed_q;
          end else begin
            idx_q       <= idx_q + LW'(1);
            mem_addr_q  <= mem_addr_q + AW'(1);
            mem_wdata_q <= mem_wdata_q + DW'(1);
          end
        end
        S_READ: begin
          if (last_word) begin
            state_q <= S_DRAIN;
            pv_q[0] <= 1'b0;
            drain_q <= 3'(RD_LAT - 1);
          end else begin
            idx_q      <= idx_q + LW'(1);
            mem_addr_q <= mem_addr_q + AW'(1);
            pa_q[0]    <= pa_q[0] + AW'(1);
            pd_q[0]    <= pd_q[0] + DW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) state_q <= S_DONE;
          else               drain_q <= drain_q - 3'd1;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (err_q == '0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_we         = mem_we_q;

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator: behavioural RAM with per-address fault injection plus a word-level reference model.
module tb_ram_initiator;

  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW:0]   mem_rdata;
  logic [AW-1:0] mem_addr_echo;

  int n_cmp = 0;
  int n_bad = 0;

  ram_initiator #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .len            (len),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata),
    .mem_addr_echo  (mem_addr_echo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle registered read; faults are applied on the read side, keyed by address.
  logic [7:0] ram    [256];
  logic [7:0] f_and  [256];
  logic [7:0] f_xor  [256];
  logic       f_par  [256];
  logic [7:0] f_echo [256];
  logic [7:0] rd_q;
  logic [7:0] echo_q;
  logic       par_q;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_q   <= ram[mem_addr];
    par_q  <= ^ram[mem_addr];
    echo_q <= mem_addr;
  end

  assign mem_rdata     = {par_q ^ f_par[echo_q], (rd_q & f_and[echo_q]) ^ f_xor[echo_q]};
  assign mem_addr_echo = echo_q ^ f_echo[echo_q];

  typedef struct {
    int         done_cyc;
    int         done_n;
    int         wr_n;
    logic       busy0;
    logic       busy_end;
    logic       pass;
    logic [8:0] errc;
    logic [7:0] ferr;
    int         ram_bad;
  } obs_t;

  function automatic int exp_lat(input logic [8:0] l);
    return (l == 9'd0) ? 1 : 2 * int'(l) + RD_LAT + 1;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      f_and[i]  = 8'hFF;
      f_xor[i]  = 8'h00;
      f_par[i]  = 1'b0;
      f_echo[i] = 8'h00;
    end
  endtask

  // Word-level reference: what each read returns given the fault tables, and which words count as errors.
  task automatic model(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s,
                       output int ec, output logic [7:0] fa);
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic       bad;
    ec = 0;
    fa = 8'h00;
    for (int i = 0; i < int'(l); i++) begin
      a   = 8'(b + i);
      d   = 8'(s + i);
      rd  = (d & f_and[a]) ^ f_xor[a];
      bad = (rd != d) || ((a ^ f_echo[a]) != a) || (PAR_EN && (((^d) ^ f_par[a]) != (^rd)));
      if (bad) begin
        if (ec == 0) fa = a;
        ec++;
      end
    end
  endtask

  task automatic run(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s,
                     input int inj, output obs_t o);
    int lim;
    o.done_cyc = -1; o.done_n = 0; o.wr_n = 0; o.ram_bad = 0;
    o.busy0 = 1'b0; o.busy_end = 1'b1;
    lim = exp_lat(l) + 40;
    @(negedge clk);
    base_addr = b; len = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < lim; cyc++) begin
      if (cyc == 0) o.busy0 = busy;
      if (mem_we) o.wr_n++;
      if (done) begin
        o.done_n++;
        if (o.done_cyc < 0) o.done_cyc = cyc;
      end
      if (o.done_cyc >= 0 && cyc == o.done_cyc + 4) begin
        o.busy_end = busy;
        break;
      end
      start = (cyc == inj);
      @(negedge clk);
    end
    start = 1'b0;
    o.pass = pass; o.errc = err_count; o.ferr = first_err_addr;
    for (int i = 0; i < int'(l); i++)
      if (ram[8'(b + i)] !== 8'(s + i)) o.ram_bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_we, pass, err_count, first_err_addr, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b pass=%b err=%0d ferr=%h addr=%h wdata=%h, all must be 0",
               busy, done, mem_we, pass, err_count, first_err_addr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    obs_t o;
    clear_faults();
    run(8'h00, 9'd8, 8'h01, -1, o);
    n_cmp++; if (o.done_cyc !== 18) begin n_bad++; $display("FAIL basic_latency: got %0d want 18", o.done_cyc); end
    n_cmp++; if (o.done_n !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", o.done_n); end
    n_cmp++; if (o.wr_n !== 8) begin n_bad++; $display("FAIL basic_write_cycles: got %0d want 8", o.wr_n); end
    n_cmp++; if (o.busy0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start: got %b want 1", o.busy0); end
    n_cmp++; if (o.busy_end !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", o.busy_end); end
    n_cmp++; if (o.pass !== 1'b1) begin n_bad++; $display("FAIL basic_pass: got %b want 1", o.pass); end
    n_cmp++; if (o.errc !== 9'd0) begin n_bad++; $display("FAIL basic_err_count: got %0d want 0", o.errc); end
    n_cmp++; if (o.ram_bad !== 0) begin n_bad++; $display("FAIL basic_ram_contents: %0d bad words, want 0", o.ram_bad); end
  endtask

  task automatic test_wrap();
    obs_t o;
    clear_faults();
    run(8'hFE, 9'd4, 8'hFF, -1, o);
    n_cmp++; if (o.done_cyc !== 10) begin n_bad++; $display("FAIL wrap_latency: got %0d want 10", o.done_cyc); end
    n_cmp++; if (o.pass !== 1'b1) begin n_bad++; $display("FAIL wrap_pass: got %b want 1", o.pass); end
    n_cmp++; if (o.ram_bad !== 0) begin n_bad++; $display("FAIL wrap_ram_contents: %0d bad words, want 0", o.ram_bad); end
    n_cmp++; if (ram[8'h00] !== 8'h01) begin n_bad++; $display("FAIL wrap_addr00: got %h want 01", ram[8'h00]); end
  endtask

  task automatic test_faults();
    obs_t       o;
    int         ec;
    logic [7:0] fa;
    for (int t = 0; t < 3; t++) begin
      clear_faults();
      case (t)
        0: begin f_and[2] = 8'hFE; f_and[5] = 8'hFE; end
        1: f_par[5] = 1'b1;
        default: f_echo[3] = 8'h10;
      endcase
      model(8'h00, 9'd8, 8'h01, ec, fa);
      run(8'h00, 9'd8, 8'h01, -1, o);
      n_cmp++; if (o.errc !== 9'(ec)) begin n_bad++; $display("FAIL fault%0d_err_count: got %0d want %0d", t, o.errc, ec); end
      n_cmp++; if (o.ferr !== fa) begin n_bad++; $display("FAIL fault%0d_first_addr: got %h want %h", t, o.ferr, fa); end
      n_cmp++; if (o.pass !== (ec == 0)) begin n_bad++; $display("FAIL fault%0d_pass: got %b want %b", t, o.pass, ec == 0); end
      n_cmp++; if (o.done_cyc !== 18) begin n_bad++; $display("FAIL fault%0d_latency: got %0d want 18", t, o.done_cyc); end
    end
    n_cmp++; if (o.errc !== 9'd1) begin n_bad++; $display("FAIL echo_err_count: got %0d want 1", o.errc); end
    n_cmp++; if (o.ferr !== 8'h03) begin n_bad++; $display("FAIL echo_first_addr: got %h want 03", o.ferr); end
    clear_faults();
  endtask

  task automatic test_len0();
    obs_t o;
    run(8'h40, 9'd0, 8'h11, -1, o);
    n_cmp++; if (o.done_cyc !== 1) begin n_bad++; $display("FAIL len0_latency: got %0d want 1", o.done_cyc); end
    n_cmp++; if (o.wr_n !== 0) begin n_bad++; $display("FAIL len0_writes: got %0d want 0", o.wr_n); end
    n_cmp++; if (o.pass !== 1'b1) begin n_bad++; $display("FAIL len0_pass: got %b want 1", o.pass); end
    n_cmp++; if (o.done_n !== 1) begin n_bad++; $display("FAIL len0_done_count: got %0d want 1", o.done_n); end
  endtask

  task automatic test_start_busy();
    obs_t o;
    run(8'h00, 9'd8, 8'h01, 3, o);
    n_cmp++; if (o.done_n !== 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d want 1", o.done_n); end
    n_cmp++; if (o.done_cyc !== 18) begin n_bad++; $display("FAIL busy_start_latency: got %0d want 18", o.done_cyc); end
    n_cmp++; if (o.busy_end !== 1'b0) begin n_bad++; $display("FAIL busy_start_restarted: busy=%b want 0", o.busy_end); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   dn;
    @(negedge clk);
    base_addr = 8'h00; len = 9'd8; seed = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL midreset_writing: mem_we=%b want 1", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_we, pass, err_count, first_err_addr, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b we=%b pass=%b err=%0d ferr=%h addr=%h wdata=%h, all must be 0",
               busy, done, mem_we, pass, err_count, first_err_addr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL midreset_no_done: %0d cycles with done/busy, want 0", dn); end
    run(8'h00, 9'd8, 8'h01, -1, o);
    n_cmp++; if (o.pass !== 1'b1) begin n_bad++; $display("FAIL midreset_rerun_pass: got %b want 1", o.pass); end
    n_cmp++; if (o.done_cyc !== 18) begin n_bad++; $display("FAIL midreset_rerun_latency: got %0d want 18", o.done_cyc); end
  endtask

  task automatic test_random();
    obs_t       o;
    int         ec;
    logic [7:0] fa;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] a;
    logic [8:0] l;
    int         nf;
    for (int r = 0; r < 8; r++) begin
      b = 8'($urandom);
      s = 8'($urandom);
      l = (r == 7) ? 9'd256 : 9'($urandom_range(1, 40));
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        a = 8'(b + $urandom_range(0, int'(l) - 1));
        case ($urandom_range(0, 3))
          0: f_xor[a]  = 8'($urandom_range(1, 255));
          1: f_and[a]  = 8'hFE;
          2: f_par[a]  = 1'b1;
          default: f_echo[a] = 8'($urandom_range(1, 255));
        endcase
      end
      model(b, l, s, ec, fa);
      run(b, l, s, -1, o);
      n_cmp++; if (o.done_cyc !== exp_lat(l)) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", r, o.done_cyc, exp_lat(l)); end
      n_cmp++; if (o.errc !== 9'(ec)) begin n_bad++; $display("FAIL rand%0d_err_count: got %0d want %0d", r, o.errc, ec); end
      n_cmp++; if (o.ferr !== fa) begin n_bad++; $display("FAIL rand%0d_first_addr: got %h want %h", r, o.ferr, fa); end
      n_cmp++; if (o.pass !== (ec == 0)) begin n_bad++; $display("FAIL rand%0d_pass: got %b want %b", r, o.pass, ec == 0); end
      n_cmp++; if (o.ram_bad !== 0) begin n_bad++; $display("FAIL rand%0d_ram_contents: %0d bad words, want 0", r, o.ram_bad); end
    end
    clear_faults();
  endtask

  initial begin
    start = 1'b0;
    base_addr = '0;
    len = '0;
    seed = '0;
    clear_faults();
    test_reset();
    test_basic();
    test_wrap();
    test_faults();
    test_len0();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
